btn_debounce_pulse: RTL and testbench

Debounces a raw mechanical push-button and produces clean one-cycle events for the small counter stages on the board. It sits directly upstream of the 2-bit ripple counter: `btn_pulse` is the counter's count stimulus, and `btn_release` and `btn_level` go to LEDs and status logic. It contains a two-flop synchronizer, a four-state debounce FSM, and an optional hold-to-auto-repeat generator.

---
 rtl/btn_debounce_pulse_if.sv | 22 ++
 rtl/btn_debounce_pulse.sv | 187 ++++++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/btn_debounce_pulse_if.sv
// Push-button bundle: the raw button toward the debouncer and its three clean
// registered outputs back to the consumer.
interface btn_debounce_pulse_if;
    logic btn_in;
    logic btn_level;
    logic btn_pulse;
    logic btn_release;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_pulse,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_pulse,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer: two-flop synchronizer, four-state debounce FSM and an
// optional hold-to-auto-repeat pulse generator sharing a single 16-bit timer.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    btn_debounce_pulse_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    // Limits are stored as "last count" so every compare is timer == limit-1.
    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [15:0] DLY_LAST = 16'(REPEAT_DELAY - 32'd1);
    localparam logic [15:0] PER_LAST = 16'(REPEAT_PERIOD - 32'd1);

    logic        r_s1;
    logic        r_s2;
    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_rpt_phase;
    logic        r_level;
    logic        r_pulse;
    logic        r_release;

    logic        w_btn_s;
    logic [15:0] w_rpt_last;
    state_t      w_state_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_rpt_phase_nxt;
    logic        w_level_nxt;
    logic        w_pulse_nxt;
    logic        w_release_nxt;

    assign w_btn_s    = r_s2;
    assign w_rpt_last = r_rpt_phase ? PER_LAST : DLY_LAST;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.btn_in;
            r_s2 <= r_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timer, repeat phase and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= 16'd0;
            r_rpt_phase <= 1'b0;
            r_level     <= 1'b0;
            r_pulse     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_timer     <= w_timer_nxt;
            r_rpt_phase <= w_rpt_phase_nxt;
            r_level     <= w_level_nxt;
            r_pulse     <= w_pulse_nxt;
            r_release   <= w_release_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = ST_PRESS_CHK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS_CHK: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == DEB_LAST) begin
                    w_state_nxt = ST_HELD;
                end else begin
                    w_state_nxt = ST_PRESS_CHK;
                end
            end
            ST_HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_RELEASE_CHK;
                end else begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_RELEASE_CHK: begin
                if (w_btn_s) begin
                    w_state_nxt = ST_HELD;
                end else if (r_timer == DEB_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RELEASE_CHK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timer/output update; a state change always restarts the timer at zero.
    always_comb begin
        w_timer_nxt     = r_timer;
        w_rpt_phase_nxt = r_rpt_phase;
        w_level_nxt     = r_level;
        w_pulse_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = 16'd0;
                w_level_nxt = 1'b0;
            end
            ST_PRESS_CHK: begin
                if (!w_btn_s) begin
                    w_timer_nxt = 16'd0;
                end else if (r_timer == DEB_LAST) begin
                    w_timer_nxt     = 16'd0;
                    w_level_nxt     = 1'b1;
                    w_pulse_nxt     = 1'b1;
                    w_rpt_phase_nxt = 1'b0;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ST_HELD: begin
                if (!w_btn_s) begin
                    w_timer_nxt = 16'd0;
                end else if ((REPEAT_EN == 1'b1) && (r_timer == w_rpt_last)) begin
                    w_timer_nxt     = 16'd0;
                    w_pulse_nxt     = 1'b1;
                    w_rpt_phase_nxt = 1'b1;
                end else if (REPEAT_EN == 1'b1) begin
                    w_timer_nxt = r_timer + 16'd1;
                end else begin
                    w_timer_nxt = 16'd0;
                end
            end
            ST_RELEASE_CHK: begin
                // A bounce back to HELD keeps rpt_phase, so repeat resumes at its current rate.
                if (w_btn_s) begin
                    w_timer_nxt = 16'd0;
                end else if (r_timer == DEB_LAST) begin
                    w_timer_nxt   = 16'd0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            default: begin
                w_timer_nxt     = 16'd0;
                w_rpt_phase_nxt = 1'b0;
                w_level_nxt     = 1'b0;
            end
        endcase
    end

    assign bus.btn_level   = r_level;
    assign bus.btn_pulse   = r_pulse;
    assign bus.btn_release = r_release;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse: a vector table for press/repeat/release
// and glitch cases, plus hand-written bounce, no-repeat and reset sequences.
module tb_btn_debounce_pulse;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    btn_debounce_pulse_if bus_a ();
    btn_debounce_pulse_if bus_b ();

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b0),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // exp = {level, pulse, release} expected just after the edge the btn value precedes.
    typedef struct packed {
        logic       btn;
        logic [2:0] exp;
    } vec_t;

    localparam int NVEC = 64;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;
    int b_pulses;
    int b_releases;

    function automatic logic [2:0] out_a();
        return {bus_a.btn_level, bus_a.btn_pulse, bus_a.btn_release};
    endfunction

    function automatic logic [2:0] out_b();
        return {bus_b.btn_level, bus_b.btn_pulse, bus_b.btn_release};
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] {level,pulse,release} actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive both buttons, then return 1 time unit after the next rising edge.
    task automatic step(input logic a, input logic b);
        bus_a.btn_in = a;
        bus_b.btn_in = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.btn_in = 1'b0;
        bus_b.btn_in = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("reset_init_a", 0, out_a(), 3'b000);
        check("reset_init_b", 0, out_b(), 3'b000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean press k=0 with repeats, release m=24 (limit hit on the exit edge 26),
        // 3- and 4-cycle glitches, then a minimum 5-cycle press at 50.
        for (int i = 0; i < NVEC; i++) begin
            vecs[i] = '0;
            vecs[i].btn    = ((i <= 23) || (i >= 32 && i <= 34) ||
                              (i >= 41 && i <= 44) || (i >= 50 && i <= 54)) ? 1'b1 : 1'b0;
            vecs[i].exp[2] = ((i >= 6 && i <= 29) || (i >= 56 && i <= 60)) ? 1'b1 : 1'b0;
            vecs[i].exp[1] = ((i == 6) || (i == 14) || (i == 18) || (i == 22) || (i == 56)) ? 1'b1 : 1'b0;
            vecs[i].exp[0] = ((i == 30) || (i == 61)) ? 1'b1 : 1'b0;
        end
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].btn, 1'b0);
            check("table", i, out_a(), vecs[i].exp);
        end

        // Release with a one-cycle bounce at m+3 (m=10): HELD again, release at m+10.
        for (int j = 0; j < 22; j++) begin
            step(((j < 10) || (j == 13)) ? 1'b1 : 1'b0, 1'b0);
            check("bounce", j, out_a(),
                  {((j >= 6) && (j < 20)) ? 1'b1 : 1'b0, (j == 6) ? 1'b1 : 1'b0, (j == 20) ? 1'b1 : 1'b0});
        end

        // No-repeat instance: hold 40 cycles, single pulse and single release.
        b_pulses   = 0;
        b_releases = 0;
        for (int j = 0; j < 60; j++) begin
            step(1'b0, (j < 40) ? 1'b1 : 1'b0);
            if (bus_b.btn_pulse === 1'b1) begin
                b_pulses++;
            end
            if (bus_b.btn_release === 1'b1) begin
                b_releases++;
            end
            check("norepeat", j, out_b(),
                  {((j >= 6) && (j <= 45)) ? 1'b1 : 1'b0, (j == 6) ? 1'b1 : 1'b0, (j == 46) ? 1'b1 : 1'b0});
        end
        check_count("norepeat_pulse_count", b_pulses, 1);
        check_count("norepeat_release_count", b_releases, 1);

        // Reset mid-hold: outputs clear without a clock edge, then a fresh press runs.
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b0);
            check("pre_reset_hold", j, out_a(),
                  {(j >= 6) ? 1'b1 : 1'b0, (j == 6) ? 1'b1 : 1'b0, 1'b0});
        end
        #3 rst = 1'b1;
        #1;
        check("reset_mid_hold", 0, out_a(), 3'b000);
        #1 rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b0);
            check("post_reset_press", j, out_a(),
                  {(j >= 6) ? 1'b1 : 1'b0, (j == 6) ? 1'b1 : 1'b0, 1'b0});
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 1'b0);
            check("post_reset_release", j, out_a(),
                  {(j < 6) ? 1'b1 : 1'b0, 1'b0, (j == 6) ? 1'b1 : 1'b0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
